// File: rtl/pwl_coef_loader_if.sv
// Coefficient stream bundle for the PWL table loader: valid/ready handshake with k/b words and a last flag.
interface pwl_coef_loader_if #(
    parameter int W = 16
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/pwl_coef_loader.sv
// Runtime loader for the PWL {k, b} coefficient table with a registered evaluator read port.
// Optional macro PWL_BANK_SWAP_EN: double-buffered table, swapped atomically on an error-free load end.
module pwl_coef_loader #(
    parameter int U       = 8,
    parameter int K_WIDTH = 16,
    parameter int B_WIDTH = 16,
    parameter int W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    pwl_coef_loader_if.slave           s,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [U:0]                 entries_loaded,
    input  logic [U-1:0]               rd_idx,
    output logic [K_WIDTH+B_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 1 << U;
    localparam int DW    = K_WIDTH + B_WIDTH;
`ifdef PWL_BANK_SWAP_EN
    localparam int AW    = U + 1;
`else
    localparam int AW    = U;
`endif

    typedef enum logic [1:0] {IDLE, GET_K, GET_B, FIN} state_t;

    state_t           state_q, state_d;
    logic [U-1:0]     addr_q;
    logic [K_WIDTH-1:0] k_q;
    logic [U:0]       entries_q;
    logic             err_q;
    logic [DW-1:0]    rd_data_q;
    logic [W-1:0]     word;
    logic             xfer;
    logic             we;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [DW-1:0]    table_mem [(1 << AW)];

    assign word = s.s_data;
    assign xfer = s.s_valid && s.s_ready;
    assign we   = (state_q == GET_B) && xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = GET_K;
            GET_K: if (xfer) state_d = s.s_last ? FIN : GET_B;
            GET_B: if (xfer) state_d = (s.s_last || (&addr_q)) ? FIN : GET_K;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s.s_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE:  ;
            GET_K, GET_B: begin
                s.s_ready = 1'b1;
                busy      = 1'b1;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Full table without s_last is an overflow: flag it and let FIN end the load before addr wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            k_q       <= '0;
            entries_q <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    addr_q    <= '0;
                    entries_q <= '0;
                    err_q     <= 1'b0;
                end
                GET_K: if (xfer) begin
                    k_q <= word[K_WIDTH-1:0];
                    if (s.s_last) err_q <= 1'b1;
                end
                GET_B: if (xfer) begin
                    addr_q    <= addr_q + U'(1);
                    entries_q <= entries_q + (U+1)'(1);
                    if (!s.s_last && (&addr_q)) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PWL_BANK_SWAP_EN
    logic active_q;
    logic swap;

    assign swap = (state_q == FIN) && !err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    active_q <= 1'b0;
        else if (swap) active_q <= ~active_q;
    end

    // Reading through the post-swap bank during FIN makes the new table visible right after done.
    assign wr_addr = {~active_q, addr_q};
    assign rd_addr = {(swap ? ~active_q : active_q), rd_idx};
`else
    assign wr_addr = addr_q;
    assign rd_addr = rd_idx;
`endif

    always_ff @(posedge clk) begin
        if (we) table_mem[wr_addr] <= {k_q, word[B_WIDTH-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= table_mem[rd_addr];
    end

    assign err            = err_q;
    assign entries_loaded = entries_q;
    assign rd_data        = rd_data_q;
endmodule

// File: tb/tb_pwl_coef_loader.sv
// Directed + randomized bench for pwl_coef_loader (U=2) against a pair-level table model.
module tb_pwl_coef_loader;
    localparam int U       = 2;
    localparam int K_WIDTH = 16;
    localparam int B_WIDTH = 16;
    localparam int W       = 16;
    localparam int DEPTH   = 1 << U;
    localparam int DW      = K_WIDTH + B_WIDTH;
`ifdef PWL_BANK_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, err;
    logic [U:0]    entries_loaded;
    logic [U-1:0]  rd_idx;
    logic [DW-1:0] rd_data;

    pwl_coef_loader_if #(.W(W)) s_if ();

    pwl_coef_loader #(.U(U), .K_WIDTH(K_WIDTH), .B_WIDTH(B_WIDTH), .W(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .s              (s_if),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .entries_loaded (entries_loaded),
        .rd_idx         (rd_idx),
        .rd_data        (rd_data)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [W-1:0]  wq [$];
    bit            lq [$];
    logic [DW-1:0] mb [2][DEPTH];
    bit            known [2];
    bit            active;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word list: npairs k/b pairs, s_last on word index last_pos (-1 = none).
    task automatic make_words(input int nwords, input int last_pos, input bit directed);
        wq.delete();
        lq.delete();
        for (int i = 0; i < nwords; i++) begin
            if (directed) wq.push_back((i % 2 == 0) ? W'(16'h0100 * (i/2 + 1)) : W'(16'h0010 * (i/2 + 1)));
            else          wq.push_back(W'($urandom));
            lq.push_back(i == last_pos);
        end
    endtask

    // Pair-level reference: walk the word list, pair k with the following b, stop on last/overflow.
    task automatic model_load(output int consumed, output int n_ent, output bit m_err, output bit finished);
        logic [K_WIDTH-1:0] kk;
        int wbank;
        wbank = SWAP ? int'(!active) : 0;
        consumed = 0; n_ent = 0; m_err = 0; finished = 0; kk = '0;
        for (int i = 0; i < wq.size() && !finished; i++) begin
            consumed++;
            if (i % 2 == 0) begin
                kk = wq[i][K_WIDTH-1:0];
                if (lq[i]) begin m_err = 1; finished = 1; end
            end else begin
                mb[wbank][n_ent] = {kk, wq[i][B_WIDTH-1:0]};
                n_ent++;
                if (lq[i]) finished = 1;
                else if (n_ent == DEPTH) begin m_err = 1; finished = 1; end
            end
        end
        if (n_ent == DEPTH) known[wbank] = 1;
        if (SWAP && finished && !m_err) active = !active;
    endtask

    task automatic check_table();
        if (!known[active]) return;
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = U'(i);
            step();
            chk($sformatf("table[%0d]", i), 64'(rd_data), 64'(mb[active][i]));
        end
    endtask

    task automatic stream(input bit toggle, input int stop_after, input bit old_known,
                          input logic [DW-1:0] old0, output int xfers, output bit got_done,
                          output bit done_on_xfer, output logic [DW-1:0] rd_at_done);
        int ptr;
        bit xf;
        ptr = 0; xfers = 0; got_done = 0; done_on_xfer = 0; rd_at_done = '0;
        rd_idx = '0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_ready", 64'(s_if.s_ready), 64'd1);
        chk("start_err", 64'(err), 64'd0);
        chk("start_entries", 64'(entries_loaded), 64'd0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (stop_after > 0 && xfers == stop_after) return;
            if (ptr < wq.size() && (!toggle || cyc % 2 == 0)) begin
                s_if.s_valid = 1'b1;
                s_if.s_data  = wq[ptr];
                s_if.s_last  = lq[ptr];
            end else begin
                s_if.s_valid = 1'b0;
                s_if.s_data  = W'($urandom);
                s_if.s_last  = 1'($urandom);
            end
            xf = s_if.s_valid && s_if.s_ready;
            step();
            if (xf) begin ptr++; xfers++; end
            if (SWAP && old_known) chk("rd_hold", 64'(rd_data), 64'(old0));
            if (done) begin
                got_done = 1; done_on_xfer = xf; rd_at_done = rd_data;
                break;
            end
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    task automatic run_load(input string name, input bit toggle);
        int cons, nent, xfers;
        bit merr, fin, gd, dox, old_known;
        logic [DW-1:0] old0, new0, rad;
        old_known = known[active];
        old0 = mb[active][0];
        model_load(cons, nent, merr, fin);
        new0 = mb[active][0];
        stream(toggle, 0, old_known, old0, xfers, gd, dox, rad);
        chk("done_seen", 64'(gd), 64'd1);
        chk("done_timing", 64'(dox), 64'd1);
        chk("xfers", 64'(xfers), 64'(cons));
        chk("entries", 64'(entries_loaded), 64'(nent));
        chk("err", 64'(err), 64'(merr));
        chk("fin_ready", 64'(s_if.s_ready), 64'd0);
        chk("fin_busy", 64'(busy), 64'd1);
        if (SWAP && old_known) chk("rd_at_done", 64'(rad), 64'(old0));
        // Offer a stray word in the cycle after FIN: it must stall.
        s_if.s_valid = 1'b1;
        s_if.s_data  = W'($urandom);
        step();
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ready", 64'(s_if.s_ready), 64'd0);
        chk("err_sticky", 64'(err), 64'(merr));
        if (known[active]) chk("rd_after_done", 64'(rd_data), 64'(new0));
        s_if.s_valid = 1'b0;
        $display("load %s: xfers=%0d entries=%0d err=%0b", name, xfers, entries_loaded, err);
        check_table();
    endtask

    initial begin
        int xfers, cons, nent;
        bit gd, dox, merr, fin;
        logic [DW-1:0] rad;
        active = 0;
        known[0] = 0; known[1] = 0;
        rst_n = 1'b0; start = 1'b0; rd_idx = '0;
        s_if.s_valid = 1'b0; s_if.s_data = '0; s_if.s_last = 1'b0;
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ready", 64'(s_if.s_ready), 64'd0);
        chk("rst_entries", 64'(entries_loaded), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        make_words(8, 7, 1'b1);
        run_load("directed_full", 1'b0);
        rd_idx = 2'd2;
        step();
        chk("rd_idx2", 64'(rd_data), 64'h0300_0030);

        make_words(8, 7, 1'b0);
        run_load("toggle_full", 1'b1);

        make_words(3, 2, 1'b0);
        run_load("last_on_k", 1'b0);

        make_words(10, -1, 1'b0);
        run_load("overflow", 1'b0);

        make_words(4, 3, 1'b0);
        run_load("partial", 1'($urandom));

        make_words(8, 7, 1'b0);
        run_load("random_full", 1'($urandom));

        // Abort with a reset once two pairs are in.
        make_words(4, -1, 1'b0);
        model_load(cons, nent, merr, fin);
        stream(1'b0, 4, 1'b0, '0, xfers, gd, dox, rad);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_err", 64'(err), 64'd0);
        chk("arst_ready", 64'(s_if.s_ready), 64'd0);
        chk("arst_entries", 64'(entries_loaded), 64'd0);
        chk("arst_rd_data", 64'(rd_data), 64'd0);
        active = 0;
        s_if.s_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        $display("load reset_abort: xfers=%0d model_pairs=%0d", xfers, nent);
        check_table();

        make_words(8, 7, 1'b0);
        run_load("after_reset", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pwl_coef_loader.md
Name: pwl_coef_loader

Overview:
- Writer side of the PWL coefficient table: takes a stream of k/b coefficient words over a valid/ready handshake.
- Packs each pair as {k, b} and writes it into an internal 2^U-entry table.
- Provides a registered read port in the same {k, b} format the PWL evaluator indexes with its top U input bits.
- Replaces the static .mem preload so the activation function can be reprogrammed at runtime.

Parameters:
- U, 8: table address width; depth is 2^U entries.
- K_WIDTH, 16: slope field width (signed, K_WIDTH_I+K_WIDTH_F of the evaluator).
- B_WIDTH, 16: intercept field width (signed).
- W, 16: input stream word width; W >= max(K_WIDTH, B_WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load at table address 0.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader accepts a word this cycle.
- s_data  in  W  coefficient word: k and b alternate, k first.
- s_last  in  1  marks the final b word of the load.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load ends.
- err  out  1  sticky load error; cleared by the next accepted start.
- entries_loaded  out  U+1  number of {k, b} pairs written by the current or last load.
- rd_idx  in  U  table read address (evaluator index).
- rd_data  out  K_WIDTH+B_WIDTH  {k, b} at rd_idx, registered.

Behaviour:
- Reset values:
  - busy=0, done=0, err=0, s_ready=0, entries_loaded=0, rd_data=0.
  - Internal address, k holding register and FSM return to IDLE.
  - Table contents are not reset.
- Reset mid-load: aborts immediately; entries already written stay, later entries keep their old contents.
- Handshake: a word transfers when s_valid && s_ready. s_ready is a registered FSM output, high only in GET_K and GET_B. s_data is sampled only on a transfer.
- Field extraction:
  - k = s_data[K_WIDTH-1:0]; b = s_data[B_WIDTH-1:0].
  - Upper bits are ignored; no sign extension and no saturation.
- FSM states: IDLE, GET_K, GET_B, FIN.
  - IDLE: s_ready=0.
    - start -> GET_K; addr<=0, entries_loaded<=0, err<=0.
    - start is ignored in every other state.
  - GET_K: on transfer, latch k -> GET_B.
    - s_last on a k word: err<=1, nothing written, -> FIN.
  - GET_B: on transfer, write table[addr]={k, b} in the same cycle; addr++; entries_loaded++.
    - s_last -> FIN. This may end a partial load; entries above addr are untouched and err stays 0.
    - Else if addr was 2^U-1 (table full, no s_last) -> err<=1, -> FIN.
    - Else -> GET_K.
  - FIN: s_ready=0, done=1 for exactly this cycle, -> IDLE.
- busy=1 in GET_K, GET_B and FIN.
- Words offered while s_ready=0 stall; they are never dropped or counted.
- Address wrap: addr never wraps within a load. The overflow rule above ends the load first.
- Read port:
  - rd_data <= table[rd_idx] every cycle (1-cycle latency), independent of FSM state.
  - A read of the address written in the same cycle returns the old entry (read-before-write).
- Throughput: one word per cycle while s_valid is held high; a full load takes 2*2^U transfer cycles plus start and FIN.

Optional Feature:
- Macro: PWL_BANK_SWAP_EN.
- Defined: two table banks plus an active-bank bit (reset 0).
  - Writes go only to the inactive bank; rd_data always reads the active bank.
  - In FIN with err=0 the active bit toggles, in the same cycle as done. The first rd_data from the new bank appears one cycle later.
  - In FIN with err=1 no swap occurs; the evaluator keeps the old table.
  - Reset mid-load: no swap.
- Undefined: single bank. Writes become visible on the read port the cycle after the write, and a partial or failed load leaves a mixed table.

Test Plan:
- U=2, start, then stream k0=0x0100,b0=0x0010,…,k3=0x0400,b3=0x0040 with s_last on b3 -> done pulses 1 cycle after the last transfer; entries_loaded=4; err=0; rd_idx=2 yields rd_data=0x0300_0030 one cycle later.
- U=2, s_valid toggled 1/0 every cycle over a full load -> identical table contents; no words lost or duplicated; s_ready low in IDLE/FIN.
- U=2, s_last asserted on the k word of pair 1 -> err=1, done pulses, entries_loaded=1, table[1] unchanged; next start clears err.
- U=2, 10 words with no s_last -> err=1 after pair 3 is written; s_ready=0 from FIN onward; the 9th word stalls.
- U=2, rst_n pulsed low after pair 1 is written -> all outputs 0 asynchronously; table[0..1] new, table[2..3] old (no macro).
- PWL_BANK_SWAP_EN, U=2, holding rd_idx=0 throughout a load -> rd_data shows the old entry until the cycle after done, then the new entry; an erroneous load never changes rd_data.
